clk_div_gen: RTL and testbench

- Runtime-programmable integer clock divider for the CLK50 domain. It produces a divided square wave (CLK_OUT) and a one-cycle clock-enable strobe (TICK) for downstream logic such as VGA timing, the game-tick timer and input debounce.
- Generalises the fixed divide-by-2 toggle to any divisor from 2 to 2^CNT_WIDTH-1.
- Divisor changes go through a valid/ready handshake and take effect only at a period boundary, so no runt pulses appear.
- All outputs are registered. CLK_OUT is a fabric signal, not a routed clock; downstream logic uses TICK as an enable.

---
 rtl/clk_pkg.sv | 16 +
 rtl/div_hs_reg.sv | 44 ++++
 rtl/clk_div_gen.sv | 129 ++++++++++++
 tb/tb_clk_div_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_pkg.sv
// Shared constants and event encoding for the programmable clock divider.
package clk_pkg;

  localparam int CNT_WIDTH_DEF = 16;
  localparam int MIN_DIV       = 2;
  localparam int DIV_25MHZ     = 2;
  localparam int DIV_1KHZ      = 50000;

  typedef enum logic [1:0] {
    EVT_STOP  = 2'd0,
    EVT_START = 2'd1,
    EVT_WRAP  = 2'd2,
    EVT_RUN   = 2'd3
  } div_evt_e;

endpackage

// File: rtl/div_hs_reg.sv
// Pending-divisor holding register: clamps the requested divisor and runs
// the valid/ready handshake until the top consumes the value.
module div_hs_reg
  import clk_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [CNT_WIDTH-1:0] i_div,
  input  logic                 i_div_valid,
  input  logic                 i_apply,
  output logic                 o_ready,
  output logic                 o_pend_vld,
  output logic [CNT_WIDTH-1:0] o_pend_div
);

  logic [CNT_WIDTH-1:0] w_min_div;
  logic [CNT_WIDTH-1:0] w_clamped;
  logic                 r_pend_vld;
  logic [CNT_WIDTH-1:0] r_pend_div;

  // Divisors of 0 or 1 would stall or degenerate the counter, so raise them to the minimum.
  assign w_min_div = CNT_WIDTH'(MIN_DIV);
  assign w_clamped = (i_div < w_min_div) ? w_min_div : i_div;

  // Capture on handshake; clear once the top has applied the value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_vld <= 1'b0;
      r_pend_div <= '0;
    end else if (i_div_valid && !r_pend_vld) begin
      r_pend_vld <= 1'b1;
      r_pend_div <= w_clamped;
    end else if (i_apply) begin
      r_pend_vld <= 1'b0;
    end
  end

  assign o_ready    = ~r_pend_vld;
  assign o_pend_vld = r_pend_vld;
  assign o_pend_div = r_pend_div;

endmodule

// File: rtl/clk_div_gen.sv
// Runtime-programmable integer clock divider producing a divided square wave
// and a one-cycle period-start strobe; divisor changes land only on period boundaries.
module clk_div_gen
  import clk_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int DEF_DIV   = DIV_25MHZ
) (
  input  logic                 CLK50,
  input  logic                 RST_N,
  input  logic                 EN,
  input  logic                 SYNC_CLR,
  input  logic [CNT_WIDTH-1:0] DIV,
  input  logic                 DIV_VALID,
  output logic                 DIV_READY,
  output logic [CNT_WIDTH-1:0] DIV_ACT,
  output logic                 CLK_OUT,
  output logic                 TICK
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_div_act;
  logic                 r_running;
  logic                 r_clk_out;
  logic                 r_tick;

  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic [CNT_WIDTH-1:0] w_div_act_nxt;
  logic                 w_running_nxt;
  logic                 w_clk_out_nxt;
  logic                 w_tick_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic [CNT_WIDTH-1:0] w_half;
  logic [CNT_WIDTH-1:0] w_last;
  logic                 w_apply;
  logic                 w_pend_vld;
  logic [CNT_WIDTH-1:0] w_pend_div;
  div_evt_e             w_evt;

  assign w_cnt_inc = r_cnt + CNT_WIDTH'(1);
  assign w_half    = r_div_act >> 1;
  assign w_last    = r_div_act - CNT_WIDTH'(1);

  // Classify this edge; EN low beats SYNC_CLR, which beats the run logic.
  always_comb begin
    w_evt = EVT_RUN;
    if (!EN) begin
      w_evt = EVT_STOP;
    end else if (!r_running || SYNC_CLR) begin
      w_evt = EVT_START;
    end else if (r_cnt == w_last) begin
      w_evt = EVT_WRAP;
    end else begin
      w_evt = EVT_RUN;
    end
  end

  assign w_apply = w_pend_vld && (w_evt != EVT_RUN);

  div_hs_reg #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_div_hs_reg (
    .i_clk       (CLK50),
    .i_rst_n     (RST_N),
    .i_div       (DIV),
    .i_div_valid (DIV_VALID),
    .i_apply     (w_apply),
    .o_ready     (DIV_READY),
    .o_pend_vld  (w_pend_vld),
    .o_pend_div  (w_pend_div)
  );

  // Next-state for counter and outputs.
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_running_nxt = r_running;
    w_clk_out_nxt = r_clk_out;
    w_tick_nxt    = 1'b0;
    w_div_act_nxt = w_apply ? w_pend_div : r_div_act;
    case (w_evt)
      EVT_STOP: begin
        w_cnt_nxt     = '0;
        w_running_nxt = 1'b0;
        w_clk_out_nxt = 1'b0;
      end
      EVT_START, EVT_WRAP: begin
        w_cnt_nxt     = '0;
        w_running_nxt = 1'b1;
        w_clk_out_nxt = 1'b1;
        w_tick_nxt    = 1'b1;
      end
      EVT_RUN: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_cnt_inc == w_half) begin
          w_clk_out_nxt = 1'b0;
        end else begin
          w_clk_out_nxt = r_clk_out;
        end
      end
      default: begin
        w_cnt_nxt     = '0;
        w_running_nxt = 1'b0;
        w_clk_out_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK50 or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt     <= '0;
      r_running <= 1'b0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
      r_div_act <= CNT_WIDTH'(DEF_DIV);
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_running <= w_running_nxt;
      r_clk_out <= w_clk_out_nxt;
      r_tick    <= w_tick_nxt;
      r_div_act <= w_div_act_nxt;
    end
  end

  assign DIV_ACT = r_div_act;
  assign CLK_OUT = r_clk_out;
  assign TICK    = r_tick;

endmodule

// File: tb/tb_clk_div_gen.sv
// Randomized scoreboard bench for clk_div_gen against a phase-based reference model.
module tb_clk_div_gen;

  localparam int CW      = 16;
  localparam int DEF_DIV = 2;

  logic          CLK50;
  logic          RST_N;
  logic          EN;
  logic          SYNC_CLR;
  logic [CW-1:0] DIV;
  logic          DIV_VALID;
  logic          DIV_READY;
  logic [CW-1:0] DIV_ACT;
  logic          CLK_OUT;
  logic          TICK;

  typedef struct {
    logic          tick;
    logic          clk_out;
    logic [CW-1:0] div_act;
    logic          ready;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: position within the current period plus the pending slot.
  bit m_running;
  int m_phase;
  int m_n;
  bit m_pend;
  int m_pdiv;

  clk_div_gen #(.CNT_WIDTH(CW), .DEF_DIV(DEF_DIV)) dut (
    .CLK50     (CLK50),
    .RST_N     (RST_N),
    .EN        (EN),
    .SYNC_CLR  (SYNC_CLR),
    .DIV       (DIV),
    .DIV_VALID (DIV_VALID),
    .DIV_READY (DIV_READY),
    .DIV_ACT   (DIV_ACT),
    .CLK_OUT   (CLK_OUT),
    .TICK      (TICK)
  );

  initial CLK50 = 1'b0;
  always #10 CLK50 = ~CLK50;

  function automatic exp_t model_out();
    exp_t e;
    e.tick    = m_running && (m_phase == 0);
    e.clk_out = m_running && (m_phase < (m_n / 2));
    e.div_act = CW'(m_n);
    e.ready   = !m_pend;
    return e;
  endfunction

  task automatic model_step(input logic rst_n, input logic en, input logic sclr,
                            input logic [CW-1:0] d, input logic dv);
    bit cap;
    if (!rst_n) begin
      m_running = 1'b0; m_phase = 0; m_n = DEF_DIV; m_pend = 1'b0; m_pdiv = 0;
    end else begin
      cap = dv && !m_pend;
      if (!en || !m_running || sclr || (m_phase == m_n - 1)) begin
        if (m_pend) begin
          m_n    = m_pdiv;
          m_pend = 1'b0;
        end
        m_phase   = 0;
        m_running = en;
      end else begin
        m_phase = m_phase + 1;
      end
      if (cap) begin
        m_pend = 1'b1;
        m_pdiv = (int'(d) < 2) ? 2 : int'(d);
      end
    end
    exp_q.push_back(model_out());
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: after each rising edge compare outputs with the oldest expectation.
  always @(posedge CLK50) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_bit("tick", TICK, e.tick);
      check_bit("clk_out", CLK_OUT, e.clk_out);
      check_vec("div_act", DIV_ACT, e.div_act);
      check_bit("div_ready", DIV_READY, e.ready);
    end
  end

  task automatic cyc(input logic rst_n, input logic en, input logic sclr,
                     input logic [CW-1:0] d, input logic dv);
    @(negedge CLK50);
    RST_N = rst_n; EN = en; SYNC_CLR = sclr; DIV = d; DIV_VALID = dv;
    model_step(rst_n, en, sclr, d, dv);
  endtask

  task automatic idle(input logic en, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, en, 1'b0, '0, 1'b0);
  endtask

  task automatic send(input logic en, input logic [CW-1:0] d);
    bit was_pend;
    for (int i = 0; i < 64; i++) begin
      was_pend = m_pend;
      cyc(1'b1, en, 1'b0, d, 1'b1);
      if (!was_pend) break;
    end
  endtask

  task automatic async_reset_check();
    @(negedge CLK50);
    #2;
    RST_N = 1'b0;
    model_step(1'b0, EN, 1'b0, '0, 1'b0);
    #1;
    check_bit("async_rst_tick", TICK, 1'b0);
    check_bit("async_rst_clk_out", CLK_OUT, 1'b0);
    check_vec("async_rst_div_act", DIV_ACT, CW'(DEF_DIV));
    check_bit("async_rst_ready", DIV_READY, 1'b1);
  endtask

  initial begin
    RST_N = 1'b0; EN = 1'b0; SYNC_CLR = 1'b0; DIV = '0; DIV_VALID = 1'b0;
    m_running = 1'b0; m_phase = 0; m_n = DEF_DIV; m_pend = 1'b0; m_pdiv = 0;
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);

    // Default divide-by-2.
    idle(1'b1, 10);

    // Load 5 while stopped, then run.
    idle(1'b0, 2);
    send(1'b0, CW'(5));
    idle(1'b0, 2);
    idle(1'b1, 16);

    // N=4 then request 7 mid-period.
    send(1'b1, CW'(4));
    idle(1'b1, 9);
    idle(1'b1, 1);
    send(1'b1, CW'(7));
    idle(1'b1, 20);

    // Clamp of 0 and 1.
    send(1'b1, CW'(0));
    idle(1'b1, 12);
    send(1'b1, CW'(1));
    idle(1'b1, 8);

    // N=6 with SYNC_CLR at cnt=3.
    send(1'b1, CW'(6));
    for (int i = 0; i < 40 && !(m_n == 6 && m_running && m_phase == 3); i++) idle(1'b1, 1);
    cyc(1'b1, 1'b1, 1'b1, '0, 1'b0);
    idle(1'b1, 14);

    // Reset mid-period with a divisor pending.
    send(1'b1, CW'(9));
    async_reset_check();
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    idle(1'b1, 8);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 700) != 0, ($urandom % 16) != 0, ($urandom % 23) == 0,
          CW'($urandom_range(0, 9)), ($urandom % 5) == 0);
    end

    idle(1'b1, 3);
    @(negedge CLK50);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
